// File: rtl/tff_pkg.sv
// Shared definitions for the temporal flip-flop bank.
// Holds the default geometry, the per-edge operation encoding used by the
// cell's priority mux, and the max-count helper shared by RTL and bench.
package tff_pkg;

  localparam int unsigned TffBits     = 4;
  localparam int unsigned TffChannels = 4;

  // Operation selected on an edge, after clr > re > we priority is resolved.
  typedef enum logic [1:0] {
    OpHold,
    OpWrite,
    OpRead,
    OpClr
  } tff_op_e;

  // Largest duration a BITS-wide counter can store.
  function automatic int unsigned tff_max_count(int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One temporal flip-flop channel.
// Writing accumulates one count per sampled-high we edge; reading counts the
// stored value back down and raises out once the stored time has elapsed.
// Ports:
//   clk   - clock, all state changes on rising edge
//   rstb  - asynchronous active-low reset
//   we    - write enable (level, +1 per sampled-high edge)
//   re    - read enable (level, -1 per sampled-high edge, dominates we)
//   clr   - synchronous clear (highest priority)
//   out   - registered, high once stored time has elapsed during a read
//   empty - high when the count is zero
//   ovf   - registered sticky overflow flag
module tff_cell
  import tff_pkg::*;
#(
  parameter int unsigned BITS     = TffBits,
  parameter bit          SATURATE = 1'b1
) (
  input  logic clk,
  input  logic rstb,
  input  logic we,
  input  logic re,
  input  logic clr,
  output logic out,
  output logic empty,
  output logic ovf
);

  localparam logic [BITS-1:0] MaxCnt = BITS'(tff_max_count(BITS));
  localparam logic [BITS-1:0] One    = BITS'(1);

  tff_op_e         op;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    if (clr) begin
      op = OpClr;
    end else if (re) begin
      op = OpRead;
    end else if (we) begin
      op = OpWrite;
    end else begin
      op = OpHold;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    out_d = 1'b0;
    ovf_d = ovf_q;
    unique case (op)
      OpClr: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      OpRead: begin
        // Elapsed once a read edge finds nothing left; count never underflows.
        out_d = (cnt_q == '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - One;
        end
      end
      OpWrite: begin
        if (cnt_q != MaxCnt) begin
          cnt_d = cnt_q + One;
        end else begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? MaxCnt : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out   = out_q;
  assign ovf   = ovf_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/tff_bank.sv
// Bank of CHANNELS independent temporal flip-flops for the race-logic datapath.
// Channels share only clk and rstb.
// Ports:
//   clk   - clock
//   rstb  - asynchronous active-low reset
//   we    - per-channel write enable
//   re    - per-channel read enable
//   clr   - per-channel synchronous clear
//   out   - per-channel registered elapsed flag
//   empty - per-channel count-is-zero flag
//   ovf   - per-channel sticky overflow flag
module tff_bank
  import tff_pkg::*;
#(
  parameter int unsigned CHANNELS = TffChannels,
  parameter int unsigned BITS     = TffBits,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [CHANNELS-1:0] we,
  input  logic [CHANNELS-1:0] re,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] empty,
  output logic [CHANNELS-1:0] ovf
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tff_cell #(
      .BITS     (BITS),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk   (clk),
      .rstb  (rstb),
      .we    (we[i]),
      .re    (re[i]),
      .clr   (clr[i]),
      .out   (out[i]),
      .empty (empty[i]),
      .ovf   (ovf[i])
    );
  end

endmodule

// File: tb/tb_tff_bank.sv
module tb_tff_bank;
  import tff_pkg::*;

  localparam int CH = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rstb;
  logic [CH-1:0] we, re, clr;
  logic [CH-1:0] out_s, empty_s, ovf_s;
  logic [CH-1:0] out_w, empty_w, ovf_w;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: [0] saturating bank, [1] wrapping bank.
  int unsigned m_cnt[2][CH];
  bit          m_out[2][CH];
  bit          m_ovf[2][CH];
  int unsigned max_cnt;

  always #5 clk = ~clk;

  tff_bank #(.CHANNELS(CH), .BITS(BW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rstb(rstb), .we(we), .re(re), .clr(clr),
    .out(out_s), .empty(empty_s), .ovf(ovf_s)
  );

  tff_bank #(.CHANNELS(CH), .BITS(BW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rstb(rstb), .we(we), .re(re), .clr(clr),
    .out(out_w), .empty(empty_w), .ovf(ovf_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[d][c] = 0;
        m_out[d][c] = 1'b0;
        m_ovf[d][c] = 1'b0;
      end
    end
  endfunction

  // One clock edge of behaviour, straight from the channel rules.
  function automatic void model_edge(input logic [CH-1:0] w, input logic [CH-1:0] r,
                                     input logic [CH-1:0] c);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        if (c[i]) begin
          m_cnt[d][i] = 0;
          m_out[d][i] = 1'b0;
          m_ovf[d][i] = 1'b0;
        end else if (r[i]) begin
          m_out[d][i] = (m_cnt[d][i] == 0);
          if (m_cnt[d][i] > 0) m_cnt[d][i] = m_cnt[d][i] - 1;
        end else if (w[i]) begin
          m_out[d][i] = 1'b0;
          if (m_cnt[d][i] < max_cnt) begin
            m_cnt[d][i] = m_cnt[d][i] + 1;
          end else begin
            m_ovf[d][i] = 1'b1;
            m_cnt[d][i] = (d == 0) ? max_cnt : 0;
          end
        end else begin
          m_out[d][i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [CH-1:0] eo[2], ee[2], ev[2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        eo[d][i] = m_out[d][i];
        ee[d][i] = (m_cnt[d][i] == 0);
        ev[d][i] = m_ovf[d][i];
      end
    end
    check({tag, "_sat_out"},    32'(out_s),   32'(eo[0]));
    check({tag, "_sat_empty"},  32'(empty_s), 32'(ee[0]));
    check({tag, "_sat_ovf"},    32'(ovf_s),   32'(ev[0]));
    check({tag, "_wrap_out"},   32'(out_w),   32'(eo[1]));
    check({tag, "_wrap_empty"}, 32'(empty_w), 32'(ee[1]));
    check({tag, "_wrap_ovf"},   32'(ovf_w),   32'(ev[1]));
  endtask

  task automatic step(input string tag, input logic [CH-1:0] w, input logic [CH-1:0] r,
                      input logic [CH-1:0] c);
    we  = w;
    re  = r;
    clr = c;
    @(posedge clk);
    model_edge(w, r, c);
    #1;
    check_all(tag);
  endtask

  // Hold re on one channel and report the edge number on which out first rises
  // in each bank (0 if it never does within the budget).
  task automatic read_until(input string tag, input int ch, input int budget,
                            output int n_s, output int n_w);
    n_s = 0;
    n_w = 0;
    for (int k = 1; k <= budget; k++) begin
      step(tag, '0, CH'(1) << ch, '0);
      if (n_s == 0 && out_s[ch]) n_s = k;
      if (n_w == 0 && out_w[ch]) n_w = k;
      if (n_s != 0 && n_w != 0) break;
    end
  endtask

  task automatic async_reset(input string tag);
    we  = CH'($urandom);
    re  = CH'($urandom);
    clr = '0;
    @(posedge clk);
    model_edge(we, re, clr);
    #3;
    rstb = 1'b0;
    #1;
    // No clock edge has occurred since rstb fell.
    check({tag, "_out"},   32'({out_s, out_w}),     32'(0));
    check({tag, "_ovf"},   32'({ovf_s, ovf_w}),     32'(0));
    check({tag, "_empty"}, 32'({empty_s, empty_w}), 32'({(2 * CH) {1'b1}}));
    model_reset();
    #2;
    rstb = 1'b1;
  endtask

  initial begin
    int ns, nw;
    max_cnt = tff_max_count(BW);
    we   = '0;
    re   = '0;
    clr  = '0;
    rstb = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset_empty_const", 32'(empty_s), 32'({CH{1'b1}}));
    @(negedge clk);
    rstb = 1'b1;

    // Round trip on ch0: 3 writes then read, out after the 4th read edge.
    repeat (3) step("rt_wr", 4'b0001, '0, '0);
    check("rt_empty0", 32'(empty_s[0]), 32'(0));
    read_until("rt_rd", 0, 10, ns, nw);
    check("rt_out_edge_sat", 32'(ns), 32'(4));
    check("rt_out_edge_wrap", 32'(nw), 32'(4));
    check("rt_others_empty", 32'(empty_s[CH-1:1]), 32'({(CH - 1) {1'b1}}));
    step("rt_idle", '0, '0, '0);

    // Temporal subtraction on ch1: 5 - 2 + 1 = 4, out after 5th read edge.
    repeat (5) step("sub_wr", 4'b0010, '0, '0);
    repeat (2) step("sub_rd", '0, 4'b0010, '0);
    step("sub_idle", '0, '0, '0);
    step("sub_wr1", 4'b0010, '0, '0);
    read_until("sub_rd2", 1, 10, ns, nw);
    check("sub_out_edge", 32'(ns), 32'(5));
    step("sub_idle2", '0, '0, '0);

    // Overflow on ch3.
    repeat (16) step("ovf_wr", 4'b1000, '0, '0);
    check("ovf_wrap_empty", 32'(empty_w[3]), 32'(1));
    check("ovf_wrap_flag", 32'(ovf_w[3]), 32'(1));
    step("ovf_wr17", 4'b1000, '0, '0);
    check("ovf_sat_flag", 32'(ovf_s[3]), 32'(1));
    read_until("ovf_rd", 3, 20, ns, nw);
    check("ovf_sat_residual", 32'(ns), 32'(16));
    check("ovf_wrap_residual", 32'(nw), 32'(2));
    repeat (3) step("ovf_wr2", 4'b1000, '0, '0);
    step("ovf_clr", '0, '0, 4'b1000);
    check("ovf_clr_flags", 32'({ovf_s[3], ovf_w[3]}), 32'(0));
    check("ovf_clr_empty", 32'({empty_s[3], empty_w[3]}), 32'(2'b11));

    // we+re on ch2 holding 2: read only, out after 3rd edge.
    repeat (2) step("wr_re_fill", 4'b0100, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      step("wr_re", 4'b0100, 4'b0100, '0);
      check($sformatf("wr_re_out_e%0d", k), 32'(out_s[2]), 32'(k == 3));
    end
    check("wr_re_empty", 32'(empty_s[2]), 32'(1));
    step("wr_re_idle", '0, '0, '0);
    check("wr_re_out_fall", 32'(out_s[2]), 32'(0));

    // Read of an empty channel.
    step("empty_rd", '0, 4'b0001, '0);
    check("empty_rd_out", 32'(out_s[0]), 32'(1));
    check("empty_rd_cnt", 32'(empty_s[0]), 32'(1));
    check("empty_rd_ovf", 32'(ovf_s[0]), 32'(0));
    step("empty_rd_idle", '0, '0, '0);

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0] w, r, c;
      w = CH'($urandom);
      r = CH'($urandom) & CH'($urandom);
      c = CH'($urandom) & CH'($urandom) & CH'($urandom) & CH'($urandom);
      if (n % 100 == 99) begin
        async_reset("rnd_rst");
        step("rnd_after_rst", 4'b1111, '0, '0);
      end else begin
        step("rnd", w, r, c);
      end
    end

    // Deliberate overflow through random-free writes then a final reset check.
    repeat (20) step("fin_wr", 4'b1111, '0, '0);
    async_reset("fin_rst");
    step("fin_idle", '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
